// File: rtl/w_word_reader.sv
// w_word_reader
//  Reader side of the W-schedule interface. Captures a finished packed W vector
//  from the schedule builder into a local buffer, then streams it to the
//  compression-round engine one word per valid/ready transfer, index 0..W_LENGTH-1.
//
//  State table
//   state  | meaning
//   IDLE   | waiting for an armed w_vector_complete; no output valid
//   STREAM | w_valid high, presenting buffer word[index]
//   DONE   | last word accepted; read_done pulses for this one cycle
//
//  Ports
//   i_clock              rising-edge clock
//   i_reset              asynchronous active-low reset
//   i_w_vector_complete  builder flag: i_w_vector holds a finished schedule
//   i_w_vector           packed schedule, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   i_abort              synchronous cancel of the current read
//   i_w_ready            round engine accepts a word this cycle
//   o_w_vector_ack       one-cycle pulse after the vector is captured
//   o_w_valid            o_w_word / o_w_index / o_w_last are valid
//   o_w_word             current schedule word
//   o_w_index            index of o_w_word
//   o_w_last             high with o_w_valid on the final index
//   o_busy               high in STREAM and DONE
//   o_read_done          one-cycle pulse after the last word is accepted
module w_word_reader #(
   parameter int W_LENGTH   = 64,
   parameter int WORD_WIDTH = 32,
   parameter int VEC_WIDTH  = W_LENGTH * WORD_WIDTH,
   parameter int IDX_W      = $clog2(W_LENGTH)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_w_vector_complete,
   input  logic [VEC_WIDTH-1:0]  i_w_vector,
   input  logic                  i_abort,
   input  logic                  i_w_ready,
   output logic                  o_w_vector_ack,
   output logic                  o_w_valid,
   output logic [WORD_WIDTH-1:0] o_w_word,
   output logic [IDX_W-1:0]      o_w_index,
   output logic                  o_w_last,
   output logic                  o_busy,
   output logic                  o_read_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [WORD_WIDTH-1:0] r_buf [W_LENGTH];
   logic [IDX_W-1:0]      r_index;
   logic                  r_armed;
   logic                  r_ack;

   logic w_capture;
   logic w_transfer;
   logic w_at_last;

   assign w_capture  = (r_state == IDLE) && i_w_vector_complete && r_armed && !i_abort;
   assign w_transfer = (r_state == STREAM) && i_w_ready;
   assign w_at_last  = (r_index == IDX_W'(W_LENGTH - 1));

   // state register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic; abort overrides everything, including a final transfer
   always_comb begin
      w_next_state = r_state;
      if (i_abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_capture) w_next_state = STREAM;
            STREAM:  if (w_transfer && w_at_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // datapath: buffer, index, re-arm flag, ack pulse
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < W_LENGTH; i++) r_buf[i] <= '0;
         r_index <= '0;
         r_armed <= 1'b1;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= w_capture;
         // a held complete must not retrigger a read; it has to drop first
         if (w_capture) begin
            r_armed <= 1'b0;
         end else if (!i_w_vector_complete) begin
            r_armed <= 1'b1;
         end
         if (w_capture) begin
            for (int i = 0; i < W_LENGTH; i++) begin
               r_buf[i] <= i_w_vector[i*WORD_WIDTH +: WORD_WIDTH];
            end
         end
         if (i_abort || w_capture || (r_state == DONE)) begin
            r_index <= '0;
         end else if (w_transfer && !w_at_last) begin
            r_index <= r_index + 1'b1;
         end
      end
   end

   // outputs; word/index/last forced to zero whenever nothing is valid
   always_comb begin
      o_w_valid      = (r_state == STREAM);
      o_busy         = (r_state == STREAM) || (r_state == DONE);
      o_read_done    = (r_state == DONE);
      o_w_vector_ack = r_ack;
      o_w_word       = '0;
      o_w_index      = '0;
      o_w_last       = 1'b0;
      if (r_state == STREAM) begin
         o_w_word  = r_buf[r_index];
         o_w_index = r_index;
         o_w_last  = w_at_last;
      end
   end

endmodule
